// File: rtl/interleaver_pkg.sv
// Shared constants, state encoding and size-select helper for the interleaver
// input/output sequencing controller.
package interleaver_pkg;

  localparam int unsigned BYTES_SMALL_DEF = 32'd132;
  localparam int unsigned BYTES_LARGE_DEF = 32'd768;
  localparam int unsigned BITS_SMALL_DEF  = 32'd1056;
  localparam int unsigned BITS_LARGE_DEF  = 32'd6144;

  localparam int BYTE_CNT_W = 10;
  localparam int BIT_IND_W  = 14;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_WAIT    = 3'd3,
    ST_STREAM  = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  function automatic int unsigned size_sel(input logic k_large,
                                           input int unsigned small_v,
                                           input int unsigned large_v);
    return k_large ? large_v : small_v;
  endfunction

endpackage

// File: rtl/blk_counter.sv
// Loadable up-counter that stops at a programmable terminal value; used for
// both the byte count and the serial bit index.
module blk_counter #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         inc,
  input  logic [W-1:0] terminal,
  output logic [W-1:0] count,
  output logic         at_term
);

  logic [W-1:0] count_r;

  // count register: clear beats load beats increment; increment stalls at terminal
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r <= {W{1'b0}};
    end else if (clr) begin
      count_r <= {W{1'b0}};
    end else if (load) begin
      count_r <= load_val;
    end else if (inc && (count_r != terminal)) begin
      count_r <= count_r + W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign count   = count_r;
  assign at_term = (count_r == terminal);

endmodule

// File: rtl/interleaver_ctrl.sv
// Sequences byte loading, remap capture and serial bit streaming for one
// interleaver block of 1056 or 6144 bits.
module interleaver_ctrl
  import interleaver_pkg::*;
#(
  parameter int unsigned BYTES_SMALL = BYTES_SMALL_DEF,
  parameter int unsigned BYTES_LARGE = BYTES_LARGE_DEF,
  parameter int unsigned BITS_SMALL  = BITS_SMALL_DEF,
  parameter int unsigned BITS_LARGE  = BITS_LARGE_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  k_size_6144,
  input  logic                  byte_valid,
  input  logic                  ready_in,
  output logic                  shift_en,
  output logic [BYTE_CNT_W-1:0] byte_count,
  output logic                  capture,
  output logic [BIT_IND_W-1:0]  bit_ind,
  output logic                  out_valid,
  output logic                  k_latched,
  output logic                  busy,
  output logic                  block_done,
  output logic                  byte_drop
);

  state_t                state_r;
  logic                  k_latched_r;
  logic                  capture_r;
  logic                  block_done_r;
  logic                  busy_r;

  logic [BYTE_CNT_W-1:0] nbytes_s;
  logic [BIT_IND_W-1:0]  bit_last_s;
  logic [BYTE_CNT_W-1:0] byte_count_s;
  logic [BIT_IND_W-1:0]  bit_ind_s;
  logic                  byte_at_term_s;
  logic                  bit_at_term_s;
  logic                  last_byte_s;

  logic                  shift_en_s;
  logic                  byte_drop_s;
  logic                  out_valid_s;
  logic                  byte_load_s;
  logic                  byte_inc_s;
  logic                  byte_clr_s;
  logic                  bit_inc_s;
  logic                  bit_clr_s;

  // Sizes follow the frozen block size, never the live k_size_6144 input.
  assign nbytes_s    = BYTE_CNT_W'(size_sel(k_latched_r, BYTES_SMALL, BYTES_LARGE));
  assign bit_last_s  = BIT_IND_W'(size_sel(k_latched_r, BITS_SMALL, BITS_LARGE) - 32'd1);
  assign last_byte_s = byte_valid && (byte_count_s == (nbytes_s - BYTE_CNT_W'(1)));

  // per-state strobes and counter controls; reset suppresses all of them
  always_comb begin
    shift_en_s  = 1'b0;
    byte_drop_s = 1'b0;
    out_valid_s = 1'b0;
    byte_load_s = 1'b0;
    byte_inc_s  = 1'b0;
    byte_clr_s  = 1'b0;
    bit_inc_s   = 1'b0;
    bit_clr_s   = 1'b0;
    if (reset) begin
      shift_en_s = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          shift_en_s  = byte_valid;
          byte_load_s = byte_valid;
        end
        ST_LOAD: begin
          shift_en_s = byte_valid;
          byte_inc_s = byte_valid;
        end
        ST_CAPTURE: begin
          byte_drop_s = byte_valid;
        end
        ST_WAIT: begin
          byte_drop_s = byte_valid;
          bit_clr_s   = 1'b1;
        end
        ST_STREAM: begin
          byte_drop_s = byte_valid;
          out_valid_s = ready_in;
          bit_inc_s   = ready_in;
        end
        ST_DONE: begin
          byte_drop_s = byte_valid;
          byte_clr_s  = 1'b1;
          bit_clr_s   = 1'b1;
        end
        default: begin
          byte_clr_s = 1'b1;
          bit_clr_s  = 1'b1;
        end
      endcase
    end
  end

  blk_counter #(.W(BYTE_CNT_W)) u_byte_cnt (
    .clk      (clk),
    .reset    (reset),
    .clr      (byte_clr_s),
    .load     (byte_load_s),
    .load_val (BYTE_CNT_W'(1)),
    .inc      (byte_inc_s),
    .terminal (nbytes_s),
    .count    (byte_count_s),
    .at_term  (byte_at_term_s)
  );

  blk_counter #(.W(BIT_IND_W)) u_bit_cnt (
    .clk      (clk),
    .reset    (reset),
    .clr      (bit_clr_s),
    .load     (1'b0),
    .load_val ({BIT_IND_W{1'b0}}),
    .inc      (bit_inc_s),
    .terminal (bit_last_s),
    .count    (bit_ind_s),
    .at_term  (bit_at_term_s)
  );

  // block sequencer with registered capture/done/busy strobes
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      k_latched_r  <= 1'b0;
      capture_r    <= 1'b0;
      block_done_r <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      capture_r    <= 1'b0;
      block_done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (byte_valid) begin
            k_latched_r <= k_size_6144;
            busy_r      <= 1'b1;
            state_r     <= ST_LOAD;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_LOAD: begin
          // a full count without a last-byte event only arises after an upset
          if (last_byte_s || byte_at_term_s) begin
            capture_r <= 1'b1;
            state_r   <= ST_CAPTURE;
          end else begin
            state_r <= ST_LOAD;
          end
        end
        ST_CAPTURE: begin
          state_r <= ST_WAIT;
        end
        ST_WAIT: begin
          if (ready_in) begin
            state_r <= ST_STREAM;
          end else begin
            state_r <= ST_WAIT;
          end
        end
        ST_STREAM: begin
          if (ready_in && bit_at_term_s) begin
            block_done_r <= 1'b1;
            state_r      <= ST_DONE;
          end else begin
            state_r <= ST_STREAM;
          end
        end
        ST_DONE: begin
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign shift_en   = shift_en_s;
  assign byte_drop  = byte_drop_s;
  assign out_valid  = out_valid_s;
  assign byte_count = byte_count_s;
  assign bit_ind    = bit_ind_s;
  assign capture    = capture_r;
  assign block_done = block_done_r;
  assign busy       = busy_r;
  assign k_latched  = k_latched_r;

endmodule

// File: tb/tb_interleaver_ctrl.sv
// Directed self-checking bench for interleaver_ctrl: load, capture, streaming,
// drop, mid-block reset, size freeze and back-to-back blocks.
module tb_interleaver_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        k_size_6144;
  logic        byte_valid;
  logic        ready_in;
  logic        shift_en;
  logic [9:0]  byte_count;
  logic        capture;
  logic [13:0] bit_ind;
  logic        out_valid;
  logic        k_latched;
  logic        busy;
  logic        block_done;
  logic        byte_drop;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  interleaver_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .k_size_6144 (k_size_6144),
    .byte_valid  (byte_valid),
    .ready_in    (ready_in),
    .shift_en    (shift_en),
    .byte_count  (byte_count),
    .capture     (capture),
    .bit_ind     (bit_ind),
    .out_valid   (out_valid),
    .k_latched   (k_latched),
    .busy        (busy),
    .block_done  (block_done),
    .byte_drop   (byte_drop)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // bytes numbered first..last; byte_count before byte i must be i-1
  task automatic send_bytes(input int first, input int last, output int errs);
    errs = 0;
    for (int i = first; i <= last; i++) begin
      byte_valid = 1'b1;
      #1;
      if (shift_en !== 1'b1 || byte_count !== 10'(i - 1)) errs++;
      tick();
    end
    byte_valid = 1'b0;
  endtask

  task automatic stream_run(input int first, input int last, output int errs);
    errs = 0;
    for (int j = first; j <= last; j++) begin
      ready_in = 1'b1;
      #1;
      if (out_valid !== 1'b1 || bit_ind !== 14'(j) || block_done !== 1'b0) errs++;
      tick();
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int e;
    int cyc;
    int expi;
    int nv;

    reset = 1'b1; k_size_6144 = 1'b0; byte_valid = 1'b0; ready_in = 1'b0;
    tick(); tick();
    #1;
    chk("rst_byte_count", byte_count, 0);
    chk("rst_bit_ind", bit_ind, 0);
    chk("rst_k_latched", k_latched, 0);
    chk("rst_busy", busy, 0);
    chk("rst_capture", capture, 0);
    chk("rst_block_done", block_done, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_shift_en", shift_en, 0);
    chk("rst_byte_drop", byte_drop, 0);

    // block A: small, ready held high
    tick();
    reset = 1'b0; ready_in = 1'b1;
    send_bytes(1, 132, e);
    chk("a_load_seq", e, 0);
    #1;
    chk("a_capture", capture, 1);
    chk("a_cap_byte_count", byte_count, 132);
    chk("a_k_latched", k_latched, 0);
    chk("a_busy", busy, 1);
    chk("a_cap_out_valid", out_valid, 0);
    tick(); #1;
    chk("a_wait_capture", capture, 0);
    chk("a_wait_out_valid", out_valid, 0);
    chk("a_wait_bit_ind", bit_ind, 0);
    tick();
    stream_run(0, 1055, e);
    chk("a_stream_seq", e, 0);
    #1;
    chk("a_done_pulse", block_done, 1);
    chk("a_done_out_valid", out_valid, 0);

    // block B: byte_valid on the first IDLE cycle after DONE
    tick();
    byte_valid = 1'b1;
    #1;
    chk("b_idle_block_done", block_done, 0);
    chk("b_idle_busy", busy, 0);
    chk("b_idle_shift_en", shift_en, 1);
    tick();
    byte_valid = 1'b0;
    #1;
    chk("b_first_byte_count", byte_count, 1);
    chk("b_busy", busy, 1);
    send_bytes(2, 132, e);
    chk("b_load_seq", e, 0);
    #1;
    chk("b_capture", capture, 1);
    ready_in = 1'b0;
    tick(); tick(); #1;
    chk("b_wait_hold_out_valid", out_valid, 0);
    chk("b_wait_hold_bit_ind", bit_ind, 0);
    chk("b_wait_hold_busy", busy, 1);
    ready_in = 1'b1;
    tick();
    stream_run(0, 299, e);
    chk("b_stream_seq1", e, 0);
    byte_valid = 1'b1;
    #1;
    chk("b_drop", byte_drop, 1);
    chk("b_drop_shift_en", shift_en, 0);
    chk("b_drop_out_valid", out_valid, 1);
    tick();
    byte_valid = 1'b0;
    #1;
    chk("b_drop_byte_count", byte_count, 132);
    chk("b_after_drop_bit_ind", bit_ind, 301);
    chk("b_after_drop_byte_drop", byte_drop, 0);
    stream_run(301, 499, e);
    chk("b_stream_seq2", e, 0);

    // reset at bit 500 with byte_valid and ready_in also high
    reset = 1'b1; byte_valid = 1'b1; ready_in = 1'b1;
    #1;
    chk("r_bit_ind_500", bit_ind, 500);
    chk("r_prio_shift_en", shift_en, 0);
    chk("r_prio_byte_drop", byte_drop, 0);
    chk("r_prio_out_valid", out_valid, 0);
    tick();
    reset = 1'b0; byte_valid = 1'b0; ready_in = 1'b0;
    #1;
    chk("r_byte_count", byte_count, 0);
    chk("r_bit_ind", bit_ind, 0);
    chk("r_busy", busy, 0);
    chk("r_capture", capture, 0);
    chk("r_block_done", block_done, 0);
    chk("r_out_valid", out_valid, 0);
    e = 0;
    for (int i = 0; i < 5; i++) begin
      tick(); #1;
      if (block_done !== 1'b0 || busy !== 1'b0) e++;
    end
    chk("r_no_done_after", e, 0);

    // block C: k switches to 1 at byte 50, block stays small
    k_size_6144 = 1'b0; ready_in = 1'b1;
    send_bytes(1, 49, e);
    chk("c_load_seq1", e, 0);
    k_size_6144 = 1'b1;
    send_bytes(50, 132, e);
    chk("c_load_seq2", e, 0);
    #1;
    chk("c_capture", capture, 1);
    chk("c_k_latched", k_latched, 0);
    tick(); tick();
    stream_run(0, 1055, e);
    chk("c_stream_seq", e, 0);
    #1;
    chk("c_done_pulse", block_done, 1);
    tick(); #1;
    chk("c_idle_block_done", block_done, 0);
    chk("c_idle_bit_ind", bit_ind, 0);

    // block D: large, a gap in loading, ready_in toggling while streaming
    send_bytes(1, 384, e);
    chk("d_load_seq1", e, 0);
    #1;
    chk("d_k_latched", k_latched, 1);
    chk("d_gap_shift_en", shift_en, 0);
    tick(); #1;
    chk("d_gap_byte_count", byte_count, 384);
    send_bytes(385, 768, e);
    chk("d_load_seq2", e, 0);
    #1;
    chk("d_capture", capture, 1);
    chk("d_cap_byte_count", byte_count, 768);
    tick(); tick();
    cyc = 0; expi = 0; nv = 0; e = 0;
    while (expi < 6144 && cyc < 13000) begin
      ready_in = ((cyc % 2) == 0);
      #1;
      if (out_valid !== ready_in || bit_ind !== 14'(expi) || block_done !== 1'b0) e++;
      if (ready_in) begin
        nv++;
        expi++;
      end
      tick();
      cyc++;
    end
    #1;
    chk("d_stream_seq", e, 0);
    chk("d_valid_cycles", nv, 6144);
    chk("d_done_pulse", block_done, 1);
    tick(); #1;
    chk("d_idle_block_done", block_done, 0);
    chk("d_idle_byte_count", byte_count, 0);
    chk("d_idle_busy", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
